// File: rtl/seven_seg_decoder.sv
// Receive-side decoder for an 8-digit multiplexed seven-segment bus.
// Synchronizes sseg/an, waits for a stable window, and records per-digit value and status.
module seven_seg_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sseg_in,
  input  logic [7:0]  an_in,
  output logic [31:0] digits,
  output logic [7:0]  dp,
  output logic [7:0]  blank,
  output logic [7:0]  bad,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        active,
  output logic        err_multi
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_MAX   = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state_reg;
  logic [15:0]   sync1_reg, sync2_reg, key_prev_reg;
  logic [CW-1:0] stab_reg, stab_next;
  logic [TW-1:0] tmo_reg;
  logic [7:0]    seen_reg, seen_next;
  logic [31:0]   digits_reg;
  logic [7:0]    dp_reg, blank_reg, bad_reg, digit_valid_reg;
  logic          frame_done_reg, active_reg, err_multi_reg;

  logic [7:0]    an_s, sseg_s, sel, sel_rest;
  logic [6:0]    seg_on;
  logic [3:0]    dec_nibble;
  logic          dec_blank, dec_bad;
  logic          window_done, capture, multi, frame_hit;

  assign sseg_s   = sync2_reg[7:0];
  assign an_s     = sync2_reg[15:8];
  assign sel      = ~an_s;
  assign sel_rest = sel & (sel - 8'd1);
  assign seg_on   = ~sseg_s[6:0];

  always_comb begin
    if (sync2_reg != key_prev_reg)
      stab_next = CW'(1);
    else if (stab_reg != STABLE_MAX)
      stab_next = stab_reg + CW'(1);
    else
      stab_next = stab_reg;
  end

  // A window completes only on the cycle the counter first saturates.
  assign window_done = (stab_next == STABLE_MAX) && (stab_reg != STABLE_MAX);
  assign capture     = window_done && (sel != 8'd0) && (sel_rest == 8'd0);
  assign multi       = window_done && (sel_rest != 8'd0);
  assign seen_next   = seen_reg | sel;
  assign frame_hit   = (seen_next == 8'hFF);

  always_comb begin
    dec_nibble = 4'h0;
    dec_blank  = 1'b0;
    dec_bad    = 1'b0;
    case (seg_on)
      7'h3F: dec_nibble = 4'h0;
      7'h06: dec_nibble = 4'h1;
      7'h5B: dec_nibble = 4'h2;
      7'h4F: dec_nibble = 4'h3;
      7'h66: dec_nibble = 4'h4;
      7'h6D: dec_nibble = 4'h5;
      7'h7D: dec_nibble = 4'h6;
      7'h07: dec_nibble = 4'h7;
      7'h7F: dec_nibble = 4'h8;
      7'h6F: dec_nibble = 4'h9;
      7'h77: dec_nibble = 4'hA;
      7'h7C: dec_nibble = 4'hB;
      7'h39: dec_nibble = 4'hC;
      7'h5E: dec_nibble = 4'hD;
      7'h79: dec_nibble = 4'hE;
      7'h71: dec_nibble = 4'hF;
      7'h00: dec_blank  = 1'b1;
      default: dec_bad  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg       <= 16'hFFFF;
      sync2_reg       <= 16'hFFFF;
      key_prev_reg    <= 16'hFFFF;
      stab_reg        <= '0;
      tmo_reg         <= '0;
      seen_reg        <= '0;
      state_reg       <= IDLE;
      digits_reg      <= '0;
      dp_reg          <= '0;
      blank_reg       <= '0;
      bad_reg         <= '0;
      digit_valid_reg <= '0;
      frame_done_reg  <= 1'b0;
      active_reg      <= 1'b0;
      err_multi_reg   <= 1'b0;
    end else begin
      sync1_reg      <= {an_in, sseg_in};
      sync2_reg      <= sync1_reg;
      key_prev_reg   <= sync2_reg;
      stab_reg       <= stab_next;
      frame_done_reg <= 1'b0;
      if (multi)
        err_multi_reg <= 1'b1;
      if (capture) begin
        for (int i = 0; i < 8; i++) begin
          if (sel[i]) begin
            digits_reg[4*i +: 4] <= dec_nibble;
            dp_reg[i]            <= ~sseg_s[7];
            blank_reg[i]         <= dec_blank;
            bad_reg[i]           <= dec_bad;
          end
        end
        digit_valid_reg <= digit_valid_reg | sel;
        seen_reg        <= frame_hit ? 8'h00 : seen_next;
        frame_done_reg  <= frame_hit;
        state_reg       <= LOCK;
        active_reg      <= 1'b1;
        tmo_reg         <= '0;
      end else if (state_reg == LOCK) begin
        // Idle drops validity but keeps the last decoded values visible.
        if (tmo_reg == TIMEOUT_LAST) begin
          state_reg       <= IDLE;
          active_reg      <= 1'b0;
          digit_valid_reg <= '0;
          seen_reg        <= '0;
          tmo_reg         <= '0;
        end else begin
          tmo_reg <= tmo_reg + TW'(1);
        end
      end
    end
  end

  assign digits      = digits_reg;
  assign dp          = dp_reg;
  assign blank       = blank_reg;
  assign bad         = bad_reg;
  assign digit_valid = digit_valid_reg;
  assign frame_done  = frame_done_reg;
  assign active      = active_reg;
  assign err_multi   = err_multi_reg;

endmodule

// File: doc/seven_seg_decoder.md
Name: seven_seg_decoder

Overview:
- Receive-side counterpart of the multiplexed seven-segment display controller: samples an 8-digit time-multiplexed sseg/an bus and reconstructs the per-digit hex nibble, decimal point and status.
- Used for loopback self-check of the display path and for reading an external board's display bus.
- Inputs are asynchronous to clk, so the block synchronizes, de-glitches and decodes them.

Parameters:
- STABLE_CYCLES, 16: consecutive identical synchronized samples required before a digit is captured (range 2..255).
- TIMEOUT_CYCLES, 1048576: cycles with no valid single-anode sample before the bus is declared idle (range 2..2^24).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- sseg_in  input  8  active-low segments: bit0=a, bit1=b … bit6=g, bit7=dp; asynchronous
- an_in  input  8  active-low anodes: bit i low selects digit i; asynchronous
- digits  output  32  nibble i (bits 4i+3:4i) is the decoded value of digit i
- dp  output  8  active-high decimal point per digit
- blank  output  8  digit i last captured with all segments a–g off
- bad  output  8  digit i last captured with an unrecognized segment pattern
- digit_valid  output  8  digit i captured at least once since reset or idle
- frame_done  output  1  one-cycle pulse when all 8 digits have been captured since the previous pulse
- active  output  1  bus currently considered alive
- err_multi  output  1  sticky: more than one anode was seen low for a full stable window

Behaviour:
- Reset (rst=1 at a clk edge) clears every output to 0, the state to IDLE, all counters, the seen mask and the synchronizer stages (loaded with 8'hFF, meaning inactive).
- Synchronizer: two flip-flop stages on the full 16-bit {an_in, sseg_in}; all logic uses stage-2 values.
- Sample key = {an_s, sseg_s}. The stability counter resets to 1 whenever the key differs from the previous cycle's key, and otherwise increments, saturating at STABLE_CYCLES.
- Decode uses active-high gfedcba = ~sseg_s[6:0]:
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
  - 00 is blank (nibble 0).
  - Any other pattern is bad (nibble 0).
- Capture fires on the cycle the counter first reaches STABLE_CYCLES with exactly one an_s bit low at index i. Registered outputs update on that edge:
  - digits[i], dp[i] (= ~sseg_s[7]), blank[i] and bad[i] are written.
  - digit_valid[i] is set and seen[i] is set.
- Latency: an input change that is then held produces an output update 2+STABLE_CYCLES cycles after it.
- At most one capture occurs per stable window. A repeated identical key does not re-capture until the key changes.
- An all-anodes-high key is an off-time gap: no capture, no error.
- Two or more anodes low for a full stable window: no capture, and err_multi is set and held until rst.
- State machine:
  - IDLE: active=0. The first capture goes to LOCK and sets active=1.
  - LOCK: each capture reloads the timeout counter to 0. Otherwise the counter increments. At TIMEOUT_CYCLES-1 the block goes to IDLE, clears digit_valid, seen and active, and holds digits, dp, blank and bad at their last values.
- frame_done: when a capture makes seen == 8'hFF, frame_done pulses on the same output-update edge and seen clears to 0 (the capturing digit is not re-counted).
- Same digit captured again before the frame completes: the registers overwrite, seen is unchanged.
- Capture on the exact cycle the timeout expires: the capture wins, and the timeout counter reloads.
- rst asserted mid-window: the partial window is discarded and no capture occurs on that edge.

Test Plan:
- Reset: hold rst 3 cycles with random inputs → all outputs 0, active=0, frame_done never pulses.
- Normal scan: drive digits 0..7 as "1234ABCF" (an=~(1<<i), active-low segments per table), dp on digit 2 only, each held 32 cycles, then 4 gap cycles with an=FF between digits → after the last digit: digits=32'hFCBA4321, dp=8'h04, digit_valid=FF, exactly one frame_done pulse, active=1. The second identical scan produces exactly one more pulse.
- Glitch rejection: hold digit 0 = "5" for 16 cycles, then glitch sseg for 15 cycles to pattern "8" → digits[3:0]=5 and no capture of 8. With STABLE_CYCLES=16, the update occurs exactly 18 cycles after the input change.
- Bad/blank: digit 3 segments gfedcba=00 → blank[3]=1, nibble 0. Digit 4 = 7'h49 → bad[4]=1, nibble 0. Neither drives err_multi.
- Multi-anode: an=8'hFC for 20 cycles → err_multi=1, no digit_valid change. Then a normal scan → captures resume and err_multi stays 1 until rst.
- Timeout: with TIMEOUT_CYCLES=64, capture 3 digits, then hold an=FF → active=0 and digit_valid=0 on cycle 64 after the last capture, digits retained. A capture at cycle 63 keeps active=1.
